keccak_out_serializer: RTL and testbench
========================================

KECCAK_OUT_SERIALIZER -- requirements
Module: keccak_out_serializer

Interface
REQ-001 SHALL have parameter BIG_FIRST, default 1: 1 = word 0 is digest bits 511:480; 0 = word 0 is digest bits 31:0.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port digest_in  input  512  hash value from the upstream core's out bus; valid while digest_ready=1.
REQ-005 SHALL have port digest_ready  input  1  upstream out_ready; level, stays high until upstream reset.
REQ-006 SHALL have port word_out  output  32  current digest word.
REQ-007 SHALL have port word_valid  output  1  word_out holds a word for transfer.
REQ-008 SHALL have port word_accept  input  1  downstream takes word_out this cycle when word_valid=1.
REQ-009 SHALL have port word_last  output  1  current word is word 15.
REQ-010 SHALL have port word_index  output  4  index 0..15 of current word.
REQ-011 SHALL have port done  output  1  all 16 words transferred for current digest.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, DONE; encoding free.
REQ-013 SHALL register digest_ready into ready_q each cycle; rise = digest_ready & ~ready_q.
REQ-014 IDLE: on rise, SHALL capture digest_in into 512-bit hold register, set word_index=0, enter SEND next cycle; otherwise stay IDLE.
REQ-015 SEND: word_valid SHALL be 1; word_out SHALL come only from the hold register, never directly from digest_in.
REQ-016 BIG_FIRST=1: word_out SHALL equal hold[511-32*k : 480-32*k] for word_index=k; BIG_FIRST=0: hold[32*k+31 : 32*k].
REQ-017 Transfer = word_valid & word_accept in same cycle; only a transfer SHALL advance word_index.
REQ-018 Without transfer, word_out, word_index, word_last SHALL hold stable (no change while stalled).
REQ-019 Transfer with word_index<15: word_index SHALL increment by 1 next cycle, state stays SEND.
REQ-020 Transfer with word_index=15: SHALL enter DONE next cycle; word_valid=0 from that cycle.
REQ-021 word_last SHALL be 1 exactly when state=SEND and word_index=15.
REQ-022 Back-to-back: with word_accept held 1, SHALL transfer one word per cycle, 16 consecutive cycles, first word on the cycle after the capture cycle.
REQ-023 DONE: done SHALL be 1, word_valid 0; state SHALL return to IDLE the cycle after digest_ready is sampled 0.
REQ-024 A rise in SEND or DONE SHALL be ignored; hold register and word_index unchanged.
REQ-025 Changes on digest_in after capture SHALL not affect word_out.
REQ-026 word_accept while word_valid=0 SHALL have no effect.
REQ-027 Latency digest_ready rise -> first word_valid SHALL be exactly 1 cycle.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, word_valid=0, word_last=0, done=0, word_index=0, ready_q=0, hold register=0, word_out=0.
REQ-029 Reset SHALL override all other inputs, including mid-SEND; no partial transfer resumes afterwards.
REQ-030 If digest_ready=1 on the first cycle after reset release, it SHALL count as a rise (ready_q=0).

Verification
REQ-031 digest_in=512'h0001_0002_..._000F_0010 (word k = k+1, BIG_FIRST=1), rise, word_accept=1 -> word_out 0x00000001..0x00000010 on 16 consecutive cycles, word_last only on 0x00000010, done=1 next cycle.
REQ-032 Same digest, BIG_FIRST=0 -> first word 0x00000010, last word 0x00000001.
REQ-033 word_accept toggling 1,0,0,1,... -> word_out/word_index stable during stalls; exactly 16 transfers, no repeats or skips.
REQ-034 After capture, digest_in changed to all-ones -> all 16 words still from captured value.
REQ-035 reset asserted after word 5 transferred -> next cycle word_valid=0, done=0, word_index=0; new rise restarts from word 0.
REQ-036 In DONE, digest_ready held 1 -> done stays 1, no new words; digest_ready=0 then rise again -> new 16-word sequence.

Source files
------------

// File: rtl/keccak_out_serializer.sv
// Serializes a captured 512-bit Keccak digest into sixteen 32-bit words over a
// valid/accept handshake. Word order is selected by BIG_FIRST.
module keccak_out_serializer #(
    parameter int BIG_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] digest_in,
    input  logic         digest_ready,
    output logic [31:0]  word_out,
    output logic         word_valid,
    input  logic         word_accept,
    output logic         word_last,
    output logic [3:0]   word_index,
    output logic         done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         ready_q, ready_d;
    logic [511:0] hold_q, hold_d;
    logic [3:0]   idx_q, idx_d;
    logic         rise;
    logic         xfer;
    logic [3:0]   sel;

    // digest_ready is a level that stays high, so only its rising edge starts a capture.
    always_comb begin
        ready_d = digest_ready;
        rise    = digest_ready & ~ready_q;
        xfer    = (state_q == ST_SEND) & word_accept;
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    hold_d  = digest_in;
                    idx_d   = 4'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!digest_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            hold_q  <= '0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    // Output word is always taken from the hold register, never from digest_in.
    always_comb begin
        sel        = (BIG_FIRST != 0) ? (4'd15 - idx_q) : idx_q;
        word_out   = hold_q[{sel, 5'b00000} +: 32];
        word_valid = (state_q == ST_SEND);
        word_last  = (state_q == ST_SEND) && (idx_q == 4'd15);
        word_index = idx_q;
        done       = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_keccak_out_serializer.sv
// Directed bench for keccak_out_serializer; runs both word orders side by side.
module tb_keccak_out_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] digest_in;
    logic         digest_ready;
    logic         word_accept;

    logic [31:0]  word_out_a, word_out_b;
    logic         word_valid_a, word_valid_b;
    logic         word_last_a, word_last_b;
    logic [3:0]   word_index_a, word_index_b;
    logic         done_a, done_b;

    int total = 0;
    int bad   = 0;

    logic [511:0] d1, d2;
    int           exp_idx;
    int           cyc;

    always #5 clk = ~clk;

    keccak_out_serializer #(.BIG_FIRST(1)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .digest_in    (digest_in),
        .digest_ready (digest_ready),
        .word_out     (word_out_a),
        .word_valid   (word_valid_a),
        .word_accept  (word_accept),
        .word_last    (word_last_a),
        .word_index   (word_index_a),
        .done         (done_a)
    );

    keccak_out_serializer #(.BIG_FIRST(0)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .digest_in    (digest_in),
        .digest_ready (digest_ready),
        .word_out     (word_out_b),
        .word_valid   (word_valid_b),
        .word_accept  (word_accept),
        .word_last    (word_last_b),
        .word_index   (word_index_b),
        .done         (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k (transmission order with BIG_FIRST=1) is base+k, placed at the top first.
    function automatic logic [511:0] mk(input logic [31:0] base);
        logic [511:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) begin
            d[(15 - k) * 32 +: 32] = base + 32'(k);
        end
        return d;
    endfunction

    initial begin
        d1 = mk(32'h0000_0001);
        d2 = mk(32'hC0DE_0000);

        reset        = 1'b1;
        digest_in    = '0;
        digest_ready = 1'b0;
        word_accept  = 1'b0;
        step();
        step();

        chk("rst_valid", {31'd0, word_valid_a}, 32'd0);
        chk("rst_last",  {31'd0, word_last_a},  32'd0);
        chk("rst_done",  {31'd0, done_a},       32'd0);
        chk("rst_index", {28'd0, word_index_a}, 32'd0);
        chk("rst_word",  word_out_a,            32'd0);
        chk("rst_word_b", word_out_b,           32'd0);

        // Ready high on the first cycle after reset release counts as a rise.
        reset        = 1'b0;
        digest_ready = 1'b1;
        digest_in    = d1;
        word_accept  = 1'b1;
        step();
        digest_in = {512{1'b1}};
        for (int k = 0; k < 16; k++) begin
            chk("bb_valid",  {31'd0, word_valid_a}, 32'd1);
            chk("bb_index",  {28'd0, word_index_a}, 32'(k));
            chk("bb_word_a", word_out_a, 32'(k + 1));
            chk("bb_word_b", word_out_b, 32'(16 - k));
            chk("bb_last",   {31'd0, word_last_a},  (k == 15) ? 32'd1 : 32'd0);
            chk("bb_last_b", {31'd0, word_last_b},  (k == 15) ? 32'd1 : 32'd0);
            step();
        end
        chk("bb_done",   {31'd0, done_a},       32'd1);
        chk("bb_done_b", {31'd0, done_b},       32'd1);
        chk("bb_novalid", {31'd0, word_valid_a}, 32'd0);
        chk("bb_nolast", {31'd0, word_last_a},  32'd0);

        // Ready held high in DONE: no restart even with a new digest present.
        digest_in = d2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("done_hold", {31'd0, done_a},       32'd1);
            chk("done_novld", {31'd0, word_valid_a}, 32'd0);
        end

        digest_ready = 1'b0;
        step();
        chk("idle_done",  {31'd0, done_a},       32'd0);
        chk("idle_valid", {31'd0, word_valid_a}, 32'd0);
        step();
        chk("idle_acc_valid", {31'd0, word_valid_a}, 32'd0);

        // New rise with stalling downstream (accept pattern 1,0,0,...).
        digest_ready = 1'b1;
        word_accept  = 1'b0;
        step();
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < 16 && cyc < 100) begin
            chk("st_valid",  {31'd0, word_valid_a}, 32'd1);
            chk("st_index",  {28'd0, word_index_a}, 32'(exp_idx));
            chk("st_word_a", word_out_a, 32'hC0DE_0000 + 32'(exp_idx));
            chk("st_word_b", word_out_b, 32'hC0DE_0000 + 32'(15 - exp_idx));
            chk("st_last",   {31'd0, word_last_a},  (exp_idx == 15) ? 32'd1 : 32'd0);
            word_accept = ((cyc % 3) == 0);
            step();
            if (word_accept) exp_idx++;
            cyc++;
        end
        chk("st_xfers", 32'(exp_idx), 32'd16);
        chk("st_done",  {31'd0, done_a}, 32'd1);

        // Reset in the middle of a transfer sequence.
        digest_ready = 1'b0;
        word_accept  = 1'b1;
        step();
        digest_in    = d1;
        digest_ready = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            chk("mr_index", {28'd0, word_index_a}, 32'(k));
            step();
        end
        chk("mr_index6", {28'd0, word_index_a}, 32'd6);
        chk("mr_word6",  word_out_a, 32'd7);
        reset = 1'b1;
        step();
        chk("mr_valid", {31'd0, word_valid_a}, 32'd0);
        chk("mr_done",  {31'd0, done_a},       32'd0);
        chk("mr_index", {28'd0, word_index_a}, 32'd0);
        chk("mr_word",  word_out_a,            32'd0);
        reset     = 1'b0;
        digest_in = d2;
        step();
        chk("rs_valid",  {31'd0, word_valid_a}, 32'd1);
        chk("rs_index",  {28'd0, word_index_a}, 32'd0);
        chk("rs_word_a", word_out_a, 32'hC0DE_0000);
        chk("rs_word_b", word_out_b, 32'hC0DE_000F);
        step();
        chk("rs_index1", {28'd0, word_index_a}, 32'd1);
        chk("rs_word1",  word_out_a, 32'hC0DE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
